cmap_ctrl: RTL

//  Run-time loadable, double-buffered false-colour palette for the spectrogram

---
 rtl/cmap_ctrl_if.sv | 26 ++
 rtl/cmap_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/cmap_ctrl_if.sv
// cmap_ctrl_if: loader, frame-sync and pixel-stream signals of the palette controller
//   slave  : palette controller side (takes loader/pixel inputs, drives colour/status)
//   master : source/sink side (drives loader/pixel inputs, observes colour/status)
interface cmap_ctrl_if #(parameter int PW = 8, parameter int CW = 8);
  logic i_ld_start;
  logic i_ld_valid;
  logic o_ld_ready;
  logic [3*CW-1:0] i_ld_rgb;
  logic o_ld_busy;
  logic o_swap_pending;
  logic o_swapped;
  logic o_bank;
  logic i_vsync;
  logic i_valid;
  logic [PW-1:0] i_pixel;
  logic o_valid;
  logic [CW-1:0] o_r, o_g, o_b;
  modport slave (
    input i_ld_start, i_ld_valid, i_ld_rgb, i_vsync, i_valid, i_pixel,
    output o_ld_ready, o_ld_busy, o_swap_pending, o_swapped, o_bank, o_valid, o_r, o_g, o_b
  );
  modport master (
    output i_ld_start, i_ld_valid, i_ld_rgb, i_vsync, i_valid, i_pixel,
    input o_ld_ready, o_ld_busy, o_swap_pending, o_swapped, o_bank, o_valid, o_r, o_g, o_b
  );
endinterface

// File: rtl/cmap_ctrl.sv
// cmap_ctrl: double-buffered false-colour palette with frame-synchronous bank swap
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : loader handshake (start/valid/ready/rgb), status (busy,
//                      swap_pending, swapped, bank), i_vsync, pixel in, colour out
module cmap_ctrl #(parameter int PW = 8, parameter int CW = 8) (
  input logic i_clk,
  input logic i_reset_n,
  cmap_ctrl_if.slave bus
);
  localparam int N = 2**PW;
  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;
  state_t state;
  logic [PW-1:0] addr;
  logic [3*CW-1:0] b0 [N];
  logic [3*CW-1:0] b1 [N];
  logic [3*CW-1:0] rd;
  logic v1;
  logic we;
  // a write coinciding with a restart is dropped
  assign we = state == LOAD && bus.i_ld_valid && bus.o_ld_ready && !bus.i_ld_start;
  // palette entries power up as a grey ramp; reset leaves them untouched
  for (genvar i = 0; i < N; i++) begin : g_ent
    localparam logic [CW-1:0] lvl = CW'((i << CW) >> PW);
    logic [3*CW-1:0] m0 = {3{lvl}};
    logic [3*CW-1:0] m1 = {3{lvl}};
    // only the shadow bank (~o_bank) is ever written
    always_ff @(posedge i_clk)
      if (we && addr == PW'(i)) begin
        if (bus.o_bank) m0 <= bus.i_ld_rgb;
        else m1 <= bus.i_ld_rgb;
      end
    assign b0[i] = m0;
    assign b1[i] = m1;
  end
  // bank is sampled on the pixel's own valid cycle, so a swap edge still reads the old bank
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      v1 <= 1'b0;
      rd <= '0;
      bus.o_valid <= 1'b0;
      {bus.o_r, bus.o_g, bus.o_b} <= '0;
    end else begin
      v1 <= bus.i_valid;
      rd <= bus.o_bank ? b1[bus.i_pixel] : b0[bus.i_pixel];
      bus.o_valid <= v1;
      if (v1) {bus.o_r, bus.o_g, bus.o_b} <= rd;
    end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      addr <= '0;
      bus.o_bank <= 1'b0;
      bus.o_ld_ready <= 1'b0;
      bus.o_ld_busy <= 1'b0;
      bus.o_swap_pending <= 1'b0;
      bus.o_swapped <= 1'b0;
    end else begin
      bus.o_swapped <= 1'b0;
      case (state)
        IDLE:
          if (bus.i_ld_start) begin
            state <= LOAD;
            addr <= '0;
            bus.o_ld_ready <= 1'b1;
            bus.o_ld_busy <= 1'b1;
          end
        LOAD:
          if (bus.i_ld_start) addr <= '0;
          else if (we) begin
            addr <= addr + 1'b1;
            if (&addr) begin
              state <= PEND;
              bus.o_ld_ready <= 1'b0;
              bus.o_swap_pending <= 1'b1;
            end
          end
        PEND:
          if (bus.i_ld_start) begin
            state <= LOAD;
            addr <= '0;
            bus.o_ld_ready <= 1'b1;
            bus.o_swap_pending <= 1'b0;
          end else if (bus.i_vsync) begin
            state <= IDLE;
            bus.o_bank <= ~bus.o_bank;
            bus.o_swapped <= 1'b1;
            bus.o_ld_busy <= 1'b0;
            bus.o_swap_pending <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
